// File: rtl/spi_slave_single.sv
// spi_slave_single: SPI peripheral with oversampled SCLK/CS/MOSI, full-duplex, any CPOL/CPHA mode,
// single-entry TX holding buffer and RX output register. Define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting.
module spi_slave_single #(
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    CPOL       = 1'b0,
    parameter bit                    CPHA       = 1'b0,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '1
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  sclkIn,
    input  logic                  csLowIn,
    input  logic                  mosiIn,
    output logic                  misoOut,
    output logic                  misoOeOut,
    input  logic [DATA_WIDTH-1:0] txDataIn,
    input  logic                  txWrEnIn,
    output logic                  txFullOut,
    output logic [DATA_WIDTH-1:0] rxDataOut,
    output logic                  rxRdyOut,
    input  logic                  rxRdEnIn,
    output logic                  rxOverrunOut,
    output logic                  txUnderrunOut,
    output logic                  frameAbortOut
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic cs_s1_q, cs_s2_q, cs_h_q;
    logic mosi_s1_q, mosi_s2_q;

    // Synchronisers are left unreset so a reset with CS still low does not look like a fresh CS fall.
    always_ff @(posedge clkIn) begin
        sclk_s1_q <= sclkIn;
        sclk_s2_q <= sclk_s1_q;
        sclk_h_q  <= sclk_s2_q;
        cs_s1_q   <= csLowIn;
        cs_s2_q   <= cs_s1_q;
        cs_h_q    <= cs_s2_q;
        mosi_s1_q <= mosiIn;
        mosi_s2_q <= mosi_s1_q;
    end

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, cs_fall;
    logic sample_edge, shift_edge;

    assign sclk_rise   = sclk_s2_q & ~sclk_h_q;
    assign sclk_fall   = ~sclk_s2_q & sclk_h_q;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign cs_fall     = cs_h_q & ~cs_s2_q;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return w[0];
`else
        return w[DATA_WIDTH-1];
`endif
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return w >> 1;
`else
        return w << 1;
`endif
    endfunction

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic                  miso_q, miso_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_rdy_q, rx_rdy_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_full_q, tx_full_d;
    logic                  need_load_q, need_load_d;
    logic                  ovr_q, ovr_d, und_q, und_d, abt_q, abt_d;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_word, rx_next;

    assign load_word = tx_full_q ? tx_buf_q : FILL_WORD;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_next = {mosi_s2_q, rx_sh_q[DATA_WIDTH-1:1]};
`else
    assign rx_next = {rx_sh_q[DATA_WIDTH-2:0], mosi_s2_q};
`endif

    always_comb begin
        state_d     = state_q;
        tx_sh_d     = tx_sh_q;
        miso_d      = miso_q;
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_rdy_d    = rx_rdy_q & ~rxRdEnIn;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        need_load_d = need_load_q;
        ovr_d       = 1'b0;
        und_d       = 1'b0;
        abt_d       = 1'b0;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    load        = 1'b1;
                    cnt_d       = '0;
                    need_load_d = 1'b0;
                    if (CPHA) begin
                        tx_sh_d = load_word;
                    end else begin
                        miso_d  = first_bit(load_word);
                        tx_sh_d = advance(load_word);
                    end
                end
            end
            ACTIVE: begin
                if (cs_s2_q) begin
                    state_d     = IDLE;
                    abt_d       = (cnt_q != '0);
                    cnt_d       = '0;
                    need_load_d = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_sh_d = rx_next;
                        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                            cnt_d       = '0;
                            rx_data_d   = rx_next;
                            rx_rdy_d    = 1'b1;
                            ovr_d       = rx_rdy_q & ~rxRdEnIn;
                            need_load_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    // First shift edge after a completed word starts the next word from the buffer.
                    if (shift_edge) begin
                        if (need_load_q) begin
                            load        = 1'b1;
                            need_load_d = 1'b0;
                            miso_d      = first_bit(load_word);
                            tx_sh_d     = advance(load_word);
                        end else begin
                            miso_d  = first_bit(tx_sh_q);
                            tx_sh_d = advance(tx_sh_q);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A load sees the pre-write buffer; a same-cycle write still lands.
        if (load) begin
            tx_full_d = 1'b0;
            und_d     = ~tx_full_q;
        end
        if (txWrEnIn) begin
            tx_buf_d  = txDataIn;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q     <= IDLE;
            tx_sh_q     <= '0;
            miso_q      <= FILL_WORD[DATA_WIDTH-1];
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_rdy_q    <= 1'b0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            need_load_q <= 1'b0;
            ovr_q       <= 1'b0;
            und_q       <= 1'b0;
            abt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_sh_q     <= tx_sh_d;
            miso_q      <= miso_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_rdy_q    <= rx_rdy_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            need_load_q <= need_load_d;
            ovr_q       <= ovr_d;
            und_q       <= und_d;
            abt_q       <= abt_d;
        end
    end

    assign misoOut       = miso_q;
    assign misoOeOut     = (state_q == ACTIVE);
    assign txFullOut     = tx_full_q;
    assign rxDataOut     = rx_data_q;
    assign rxRdyOut      = rx_rdy_q;
    assign rxOverrunOut  = ovr_q;
    assign txUnderrunOut = und_q;
    assign frameAbortOut = abt_q;

endmodule

// File: tb/tb_spi_slave_single.sv
// Bench for spi_slave_single: one instance per SPI mode, a bit-level SPI master and a word-level reference model.
`timescale 1ns/1ps
module tb_spi_slave_single;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [3:0]      sclk, csn, mosi, wr, rd;
    logic [3:0][7:0] wdat;
    wire  [3:0][7:0] rdat;
    wire  [3:0]      miso, oe, full, rdy, ovr, und, abt;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_single #(
            .DATA_WIDTH(8), .CPOL(1'((g >> 1) & 1)), .CPHA(1'(g & 1)), .FILL_WORD(8'hFF)
        ) u_dut (
            .clkIn(clk), .rstIn(rst), .sclkIn(sclk[g]), .csLowIn(csn[g]), .mosiIn(mosi[g]),
            .misoOut(miso[g]), .misoOeOut(oe[g]), .txDataIn(wdat[g]), .txWrEnIn(wr[g]),
            .txFullOut(full[g]), .rxDataOut(rdat[g]), .rxRdyOut(rdy[g]), .rxRdEnIn(rd[g]),
            .rxOverrunOut(ovr[g]), .txUnderrunOut(und[g]), .frameAbortOut(abt[g])
        );
    end

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int got_und[4] = '{default: 0};
    int got_ovr[4] = '{default: 0};
    int got_abt[4] = '{default: 0};
    int e_und[4]   = '{default: 0};
    int e_ovr[4]   = '{default: 0};
    int e_abt[4]   = '{default: 0};
    logic       m_full[4];
    logic [7:0] m_buf[4];
    logic       m_rdy[4];
    logic [7:0] m_rdata[4];
    logic [7:0] ld_w[3];
    logic [7:0] got_w[2];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (und[i] === 1'b1) got_und[i]++;
            if (ovr[i] === 1'b1) got_ovr[i]++;
            if (abt[i] === 1'b1) got_abt[i]++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i]  = 1'b0;
            m_buf[i]   = 8'h00;
            m_rdy[i]   = 1'b0;
            m_rdata[i] = 8'h00;
        end
    endtask

    task automatic model_load(input int m, output logic [7:0] w);
        w = m_full[m] ? m_buf[m] : 8'hFF;
        if (!m_full[m]) e_und[m]++;
        m_full[m] = 1'b0;
    endtask

    task automatic half(input int m, input bit rdp);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rdp && i == 1) rd[m] = 1'b1;
            if (i == 2) rd[m] = 1'b0;
        end
    endtask

    task automatic tx_write(input int m, input logic [7:0] d);
        @(negedge clk);
        wdat[m] = d;
        wr[m]   = 1'b1;
        @(negedge clk);
        wr[m]    = 1'b0;
        m_buf[m]  = d;
        m_full[m] = 1'b1;
    endtask

    task automatic rx_read(input int m);
        @(negedge clk);
        rd[m] = 1'b1;
        @(negedge clk);
        rd[m]    = 1'b0;
        m_rdy[m] = 1'b0;
    endtask

    // One CS frame of nw words; the last word carries nlast bits. rdl pulses rxRdEn in the cycle the last word completes.
    task automatic frame(input int m, input int nw, input logic [7:0] w0, input logic [7:0] w1,
                         input int nlast, input bit refill, input logic [7:0] rf, input bit rdl);
        bit cpol, cpha, last;
        logic [7:0] w;
        int nb;
        cpol = bit'((m >> 1) & 1);
        cpha = bit'(m & 1);
        @(negedge clk);
        csn[m]  = 1'b0;
        mosi[m] = cpha ? 1'b0 : w0[7];
        model_load(m, ld_w[0]);
        repeat (6) @(negedge clk);
        chk($sformatf("oe_on_m%0d", m), 32'(oe[m]), 32'd1);
        for (int k = 0; k < nw; k++) begin
            w  = (k == 0) ? w0 : w1;
            nb = (k == nw - 1) ? nlast : 8;
            if (k > 0 && cpha) model_load(m, ld_w[k]);
            got_w[k] = 8'h00;
            for (int b = 0; b < nb; b++) begin
                last = (k == nw - 1) && (b == 7) && rdl;
                if (!cpha) begin
                    got_w[k][7-b] = miso[m];
                    sclk[m] = ~cpol;
                    half(m, last);
                    sclk[m] = cpol;
                    if (b < 7) mosi[m] = w[6-b];
                    else if (k + 1 < nw) mosi[m] = w1[7];
                    half(m, 1'b0);
                end else begin
                    sclk[m] = ~cpol;
                    mosi[m] = w[7-b];
                    half(m, 1'b0);
                    got_w[k][7-b] = miso[m];
                    sclk[m] = cpol;
                    half(m, last);
                end
                if (refill && k == 0 && b == 3) tx_write(m, rf);
            end
            if (nb == 8) begin
                if (m_rdy[m] && !(rdl && k == nw - 1)) e_ovr[m]++;
                m_rdy[m]   = 1'b1;
                m_rdata[m] = w;
                if (!cpha) model_load(m, ld_w[k+1]);
            end
        end
        csn[m] = 1'b1;
        if (nlast > 0 && nlast < 8) e_abt[m]++;
        repeat (6) @(negedge clk);
        chk($sformatf("oe_off_m%0d", m), 32'(oe[m]), 32'd0);
    endtask

    task automatic check_words(input int m, input int nw, input string tag);
        for (int k = 0; k < nw; k++)
            chk($sformatf("%s_miso_w%0d_m%0d", tag, k, m), 32'(got_w[k]), 32'(ld_w[k]));
    endtask

    task automatic check_state(input int m, input string tag);
        chk($sformatf("%s_rxdata_m%0d", tag, m), 32'(rdat[m]), 32'(m_rdata[m]));
        chk($sformatf("%s_rxrdy_m%0d", tag, m), 32'(rdy[m]), 32'(m_rdy[m]));
        chk($sformatf("%s_txfull_m%0d", tag, m), 32'(full[m]), 32'(m_full[m]));
        chk($sformatf("%s_underruns_m%0d", tag, m), 32'(got_und[m]), 32'(e_und[m]));
        chk($sformatf("%s_overruns_m%0d", tag, m), 32'(got_ovr[m]), 32'(e_ovr[m]));
        chk($sformatf("%s_aborts_m%0d", tag, m), 32'(got_abt[m]), 32'(e_abt[m]));
    endtask

    task automatic check_reset(input int m, input string tag);
        chk($sformatf("%s_miso_m%0d", tag, m), 32'(miso[m]), 32'd1);
        chk($sformatf("%s_oe_m%0d", tag, m), 32'(oe[m]), 32'd0);
        chk($sformatf("%s_txfull_m%0d", tag, m), 32'(full[m]), 32'd0);
        chk($sformatf("%s_rxdata_m%0d", tag, m), 32'(rdat[m]), 32'd0);
        chk($sformatf("%s_rxrdy_m%0d", tag, m), 32'(rdy[m]), 32'd0);
        chk($sformatf("%s_pulses_m%0d", tag, m), 32'({ovr[m], und[m], abt[m]}), 32'd0);
    endtask

    initial begin
        logic [7:0] a, b, r0, r1;
        rst  = 1'b1;
        sclk = 4'b1100;
        csn  = 4'hF;
        mosi = 4'h0;
        wr   = 4'h0;
        rd   = 4'h0;
        wdat = '0;
        model_reset();
        repeat (6) @(negedge clk);
        for (int m = 0; m < 4; m++) check_reset(m, "por");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0 basic word: 0xA5 out, 0x3C in
        tx_write(0, 8'hA5);
        chk("t1_full_after_wr", 32'(full[0]), 32'd1);
        frame(0, 1, 8'h3C, 8'h00, 8, 1'b0, 8'h00, 1'b0);
        chk("t1_miso_word", 32'(got_w[0]), 32'hA5);
        chk("t1_rxdata", 32'(rdat[0]), 32'h3C);
        check_words(0, 1, "t1");
        check_state(0, "t1");
        rx_read(0);

        // Modes 1..3: two words per frame, buffer refilled mid-word, first word never read
        for (int m = 1; m < 4; m++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            tx_write(m, r0);
            frame(m, 2, 8'h81, 8'h7E, 8, 1'b1, r1, 1'b0);
            chk($sformatf("t2_rx7e_m%0d", m), 32'(rdat[m]), 32'h7E);
            check_words(m, 2, "t2");
            check_state(m, "t2");
            rx_read(m);
        end

        // Empty buffer at CS fall: fill word shifted out
        a = 8'($urandom);
        frame(0, 1, a, 8'h00, 8, 1'b0, 8'h00, 1'b0);
        chk("t3_fill", 32'(got_w[0]), 32'hFF);
        check_state(0, "t3");
        rx_read(0);

        // Partial frame aborts without touching the RX register
        a = 8'($urandom);
        tx_write(1, 8'($urandom));
        frame(1, 1, a, 8'h00, 8, 1'b0, 8'h00, 1'b0);
        frame(1, 1, 8'($urandom), 8'h00, 5, 1'b0, 8'h00, 1'b0);
        check_state(1, "t4abort");
        b = 8'($urandom);
        tx_write(1, 8'($urandom));
        frame(1, 1, b, 8'h00, 8, 1'b0, 8'h00, 1'b0);
        check_words(1, 1, "t4next");
        check_state(1, "t4next");
        rx_read(1);

        // Read in the completion cycle of a new word
        frame(0, 1, 8'($urandom), 8'h00, 8, 1'b0, 8'h00, 1'b0);
        b = 8'($urandom);
        frame(0, 1, b, 8'h00, 8, 1'b0, 8'h00, 1'b1);
        chk("t5_rxdata", 32'(rdat[0]), 32'(b));
        check_state(0, "t5");
        rx_read(0);

        // Random frames across modes
        for (int it = 0; it < 8; it++) begin
            int m, nw;
            bit pre, rdl;
            m   = int'($urandom_range(0, 3));
            nw  = int'($urandom_range(1, 2));
            pre = bit'($urandom_range(0, 1));
            rdl = bit'($urandom_range(0, 1));
            a   = 8'($urandom);
            b   = 8'($urandom);
            if (pre) tx_write(m, 8'($urandom));
            frame(m, nw, a, b, 8, nw == 2, 8'($urandom), rdl);
            check_words(m, nw, "rnd");
            check_state(m, "rnd");
        end

        // Reset in the middle of a mode-3 word
        tx_write(3, 8'($urandom));
        @(negedge clk);
        csn[3] = 1'b0;
        model_load(3, ld_w[0]);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sclk[3] = 1'b0;
            mosi[3] = 1'($urandom);
            half(3, 1'b0);
            sclk[3] = 1'b1;
            half(3, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 4; m++) check_reset(m, "t6rst");
        rst = 1'b0;
        model_reset();
        csn[3] = 1'b1;
        repeat (6) @(negedge clk);
        tx_write(3, 8'($urandom));
        a = 8'($urandom);
        frame(3, 1, a, 8'h00, 8, 1'b0, 8'h00, 1'b0);
        chk("t6_rxdata", 32'(rdat[3]), 32'(a));
        check_words(3, 1, "t6");
        check_state(3, "t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_slave_single.md
Name: spi_slave_single

Overview:
SPI peripheral (slave) endpoint: the responder side of our SPI master links, used to let external SPI masters and test fixtures talk to fabric logic. sclkIn, csLowIn and mosiIn are oversampled in the clkIn domain. It shifts full-duplex words MSB-first in any CPOL/CPHA mode. The fabric side has a single-entry TX holding buffer and an RX output register, with a ready/read handshake and error pulses.

Parameters:
DATA_WIDTH, 8, bits per SPI word (2..32)
CPOL, 0, SCLK idle level (0 low, 1 high)
CPHA, 0, 0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
FILL_WORD, all ones, word shifted out on TX underrun

Ports:
clkIn  input  1  system clock; all logic on posedge
rstIn  input  1  synchronous, active-high reset
sclkIn  input  1  SPI clock from master (asynchronous)
csLowIn  input  1  active-low chip select from master (asynchronous)
mosiIn  input  1  serial data from master (asynchronous)
misoOut  output  1  serial data to master
misoOeOut  output  1  MISO output enable; high while the synchronised CS is asserted
txDataIn  input  DATA_WIDTH  next word to send
txWrEnIn  input  1  write txDataIn into the TX buffer
txFullOut  output  1  TX buffer occupied
rxDataOut  output  DATA_WIDTH  last received word
rxRdyOut  output  1  rxDataOut holds an unread word
rxRdEnIn  input  1  acknowledge/consume rxDataOut
rxOverrunOut  output  1  one-cycle pulse: new word arrived while rxRdyOut=1
txUnderrunOut  output  1  one-cycle pulse: word load found TX buffer empty
frameAbortOut  output  1  one-cycle pulse: CS deasserted with partial word

Behaviour:
- Sync: each of sclkIn/csLowIn/mosiIn passes through a 2-flop synchroniser, plus one history flop on sclk/cs for edge detection. Requirement: SCLK period >= 8 clkIn cycles; CS setup to first edge >= 4 clkIn cycles.
- Edges: leading edge = synced SCLK leaving the CPOL level; trailing edge = returning to it. Edges are only acted on while synced CS is low.
- Reset: misoOut=FILL_WORD MSB, misoOeOut=0, txFullOut=0, rxDataOut=0, rxRdyOut=0, all pulses 0, bit counter 0, FSM IDLE. Reset mid-frame abandons the frame silently (no frameAbortOut pulse).
- FSM IDLE -> ACTIVE on synced CS falling. On entry, in the same cycle:
  - Load shift register from TX buffer. If the buffer is empty, load FILL_WORD and pulse txUnderrunOut.
  - Clear txFullOut and set bit counter 0.
  - CPHA=0: misoOut drives the MSB from the next cycle.
- ACTIVE, sample edge:
  - rxShift <= {rxShift[DATA_WIDTH-2:0], mosiSync}; counter+1.
  - When the counter reaches DATA_WIDTH: next cycle rxDataOut <= assembled word and rxRdyOut=1. If rxRdyOut was already 1 and no rxRdEnIn that cycle, pulse rxOverrunOut (data overwritten). Counter -> 0.
- ACTIVE, shift edge:
  - misoOut <= next bit.
  - At a word boundary (CPHA=0: trailing edge after last sample; CPHA=1: first leading edge of a word), the next word is loaded from the TX buffer using the underrun rule above. For CPHA=0 its MSB appears on misoOut at that same trailing edge.
- ACTIVE -> IDLE on synced CS rising. If the counter is non-zero, discard the partial word and pulse frameAbortOut. misoOeOut=0 the same cycle.
- TX buffer: txWrEnIn with txFullOut=0 writes and sets txFullOut. A write while full overwrites the buffer (caller must check txFullOut). A load and a write in the same cycle: the load sees pre-write state; the write lands in the buffer (no bypass).
- RX handshake: rxRdEnIn clears rxRdyOut the next cycle. If a new word completes the same cycle, the new word wins: rxRdyOut stays 1, no overrun.
- misoOut holds its last value while misoOeOut=0.

Optional Feature:
SPI_SLAVE_LSB_FIRST_EN: when defined, both directions shift LSB-first (rx fills from MSB downward, tx emits bit 0 first), and FILL_WORD/underrun handling is unchanged. When undefined, MSB-first only and no extra logic.

Test Plan:
- Mode 0, TX buffer=0xA5, master sends 0x3C with SCLK=clkIn/8 -> MISO bits 1,0,1,0,0,1,0,1; rxDataOut=0x3C; rxRdyOut=1; txFullOut=0; no error pulses.
- Modes 1/2/3 loop: master sends 0x81,0x7E back-to-back in one CS frame with buffer refilled in between -> both words received intact; rxOverrunOut pulses once if 0x81 is never read.
- Empty TX buffer at CS fall -> txUnderrunOut pulses once; MISO=0xFF.
- CS raised after 5 bits -> frameAbortOut pulse; rxRdyOut unchanged; the next full frame returns correct data.
- rxRdEnIn asserted the same cycle as word completion -> rxRdyOut stays 1; no overrun; rxDataOut=new word.
- rstIn asserted mid-word -> all outputs at reset values next cycle; the next frame is decoded correctly.
